lii_out_rr_arbiter: RTL and testbench
=====================================

// Module: lii_out_rr_arbiter
// PURPOSE
//  Shares one LII phy output channel between N logical kernel output streams.
//  Arbitration is round-robin. Each accepted beat is tagged with this tile's src ID and the requester's dst ID.
//  Output goes through a one-beat registered stage. Sits between HLS kernel result streams and lii_out_p* of a top wrapper.
// PARAMETERS
//  N       4    number of requesting streams (2..8)
//  PW      256  LII packing width (bits per beat)
//  SRC_ID  0    8-bit source ID driven on m_src
//  BURST   4    max consecutive beats per grant (used only with LII_ARB_BURST_EN; >=1)
// PORTS
//  aclk       in   1     clock; single clock domain
//  arstn      in   1     asynchronous, active-low reset
//  s_tdata    in   N*PW  requester payloads; stream i = [i*PW +: PW]
//  s_tvalid   in   N     requester valid
//  s_tready   out  N     requester ready; at most one bit high per cycle
//  s_dst      in   N*8   requester destination IDs; stream i = [i*8 +: 8]
//  m_tdata    out  PW    phy channel payload
//  m_tvalid   out  1     phy channel valid
//  m_tready   in   1     phy channel ready
//  m_src      out  8     source ID of the current beat
//  m_dst      out  8     destination ID of the current beat
//  m_sel      out  $clog2(N)  index of the requester that produced the current m_* beat
// BEHAVIOUR
//  Reset (arstn=0, async): m_tvalid=0, m_tdata=0, m_dst=0, m_src=SRC_ID, m_sel=0, rr pointer=0, burst count=0, state=IDLE.
//  - s_tready=0 during reset.
//  - A reset mid-transfer discards the held beat.
//  load = !m_tvalid | m_tready (the output register is empty or draining this cycle).
//  Grant (combinational): first i with s_tvalid[i]=1, searched ptr, ptr+1, ..., ptr+N-1 (mod N).
//  - s_tready[g] = load & any(s_tvalid).
//  - All other s_tready bits = 0.
//  - s_tready never depends on m_tvalid of a different stream.
//  Accept (s_tvalid[g] & s_tready[g]): at the next edge m_tdata=s_tdata[g], m_dst=s_dst[g], m_sel=g, m_tvalid=1.
//  - Latency is 1 cycle.
//  - Full throughput is 1 beat/cycle while m_tready=1.
//  load & no valid requester: m_tvalid falls to 0 at the edge; the pointer is unchanged.
//  m_tvalid=1 & m_tready=0: m_* hold stable, all s_tready=0, no pointer movement (AXIS hold rule).
//  Pointer update on accept (no burst): ptr <= (g==N-1) ? 0 : g+1.
//  Wrap-around: grant to N-1 -> ptr=0.
//  Single active requester: it gets every cycle.
//  Simultaneous valids: the lowest index at or above ptr wins; every requester waits at most N-1 grants.
//  m_src is constant SRC_ID after reset.
// CONFIGURATION
//  LII_ARB_BURST_EN defined: FSM IDLE/HOLD plus a $clog2(BURST+1)-bit beat counter.
//  - IDLE: on accept -> HOLD with owner=g, cnt=1, ptr unchanged.
//  - IDLE: if BURST==1, stay in IDLE and advance ptr as in non-burst mode.
//  - HOLD: grant is forced to owner while s_tvalid[owner]=1. On accept cnt++.
//  - HOLD: when cnt reaches BURST -> IDLE, ptr=owner+1 mod N.
//  - HOLD: at load with s_tvalid[owner]=0 -> IDLE, ptr=owner+1, and the same cycle arbitrates normally among the others. No idle bubble.
//  - HOLD: stall (load=0) keeps state and cnt.
//  LII_ARB_BURST_EN undefined: no FSM or counter; behaviour is per-beat round-robin as above and BURST is ignored.
// TESTING
//  1 Reset: arstn=0 with all s_tvalid=1 -> m_tvalid=0, s_tready=0, m_src=SRC_ID. Release -> the first m_tvalid appears 1 cycle after the first accept, m_sel=0.
//  2 Fairness, N=4, all valid, m_tready=1 -> m_sel sequence 0,1,2,3,0,1,... with 1 beat/cycle; m_dst matches s_dst of each stream.
//  3 Backpressure: m_tready=0 for 5 cycles with m_tvalid=1 -> m_tdata/m_dst/m_sel stable, s_tready=0. Then m_tready=1 -> the next grant goes to the ptr stream, no beat lost or duplicated (scoreboard).
//  4 Sparse: only s_tvalid[2] and s_tvalid[0] asserted, ptr=3 -> grant 0 then 2 then 0. Streams 1 and 3 are never readied.
//  5 Burst (LII_ARB_BURST_EN, BURST=4, all valid) -> m_sel 0,0,0,0,1,1,1,1,... Stream 0 drops valid after 2 beats -> grant moves to 1 with no bubble cycle.
//  6 Reset asserted mid-stream with m_tvalid=1 -> m_tvalid=0 immediately (async). After release, arbitration restarts at ptr=0 and state=IDLE.

Source files
------------

// File: rtl/lii_out_rr_arbiter.sv
// rtl/lii_out_rr_arbiter.sv - round-robin arbiter sharing one LII phy output channel (macro LII_ARB_BURST_EN)
module lii_out_rr_arbiter #(
    parameter int          N      = 4,
    parameter int          PW     = 256,
    parameter logic [7:0]  SRC_ID = 8'd0,
    parameter int          BURST  = 4,
    localparam int         SW     = $clog2(N)
) (
    input  logic            aclk,
    input  logic            arstn,
    input  logic [N*PW-1:0] s_tdata,
    input  logic [N-1:0]    s_tvalid,
    output logic [N-1:0]    s_tready,
    input  logic [N*8-1:0]  s_dst,
    output logic [PW-1:0]   m_tdata,
    output logic            m_tvalid,
    input  logic            m_tready,
    output logic [7:0]      m_src,
    output logic [7:0]      m_dst,
    output logic [SW-1:0]   m_sel
);

    logic [SW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] tdata_q;
    logic          tvalid_q;
    logic [7:0]    dst_q;
    logic [SW-1:0] sel_q;

    logic          load;
    logic          any_valid;
    logic          force_owner;
    logic [SW-1:0] forced_idx;
    logic [SW-1:0] base;
    logic [SW-1:0] gnt;

    function automatic logic [SW-1:0] next_idx(input logic [SW-1:0] v);
        if (v == SW'(N - 1)) begin
            return '0;
        end
        return v + SW'(1);
    endfunction

    // The output register can take a new beat when empty or draining this cycle
    assign load      = !tvalid_q || m_tready;
    assign any_valid = |s_tvalid;

`ifdef LII_ARB_BURST_EN
    localparam int CW = $clog2(BURST + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Burst FSM state register
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    // Burst FSM next state; the pointer only moves when a burst ends (or BURST==1)
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        if (load) begin
            if (state_q == ST_HOLD && s_tvalid[owner_q]) begin
                cnt_d = cnt_q + CW'(1);
                if ((cnt_q + CW'(1)) == CW'(BURST)) begin
                    state_d = ST_IDLE;
                    ptr_d   = next_idx(owner_q);
                    cnt_d   = '0;
                end
            end else begin
                // Owner went quiet: release and arbitrate among the rest this same cycle
                if (state_q == ST_HOLD) begin
                    state_d = ST_IDLE;
                    ptr_d   = next_idx(owner_q);
                    cnt_d   = '0;
                end
                if (any_valid) begin
                    if (BURST == 1) begin
                        ptr_d = next_idx(gnt);
                    end else begin
                        state_d = ST_HOLD;
                        owner_d = gnt;
                        cnt_d   = CW'(1);
                    end
                end
            end
        end
    end

    // Burst FSM outputs: pin the grant to the owner, or restart the search after it
    always_comb begin
        base        = ptr_q;
        force_owner = 1'b0;
        forced_idx  = owner_q;
        if (state_q == ST_HOLD) begin
            if (s_tvalid[owner_q]) begin
                force_owner = 1'b1;
            end else begin
                base = next_idx(owner_q);
            end
        end
    end
`else
    // Per-beat round robin: the pointer steps past every granted stream
    always_comb begin
        ptr_d       = ptr_q;
        base        = ptr_q;
        force_owner = 1'b0;
        forced_idx  = '0;
        if (load && any_valid) begin
            ptr_d = next_idx(gnt);
        end
    end
`endif

    // Round-robin pointer register
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Grant: first valid requester at or after base, wrapping modulo N
    always_comb begin : grant_search
        int   idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        gnt   = base;
        for (int k = 0; k < N; k++) begin
            idx = (int'(base) + k) % N;
            if (!found && s_tvalid[idx]) begin
                gnt   = SW'(idx);
                found = 1'b1;
            end
        end
        if (force_owner) begin
            gnt = forced_idx;
        end
    end

    // Ready goes only to the granted stream, and never while in reset
    always_comb begin
        s_tready = '0;
        if (arstn && load && any_valid) begin
            s_tready[gnt] = 1'b1;
        end
    end

    // One-beat output register; holds while the phy stalls
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            dst_q    <= '0;
            sel_q    <= '0;
        end else if (load) begin
            tvalid_q <= any_valid;
            if (any_valid) begin
                tdata_q <= s_tdata[int'(gnt)*PW +: PW];
                dst_q   <= s_dst[int'(gnt)*8 +: 8];
                sel_q   <= gnt;
            end
        end
    end

    assign m_tdata  = tdata_q;
    assign m_tvalid = tvalid_q;
    assign m_dst    = dst_q;
    assign m_sel    = sel_q;
    assign m_src    = SRC_ID;

endmodule

// File: tb/tb_lii_out_rr_arbiter.sv
// tb/tb_lii_out_rr_arbiter.sv - self-checking bench for lii_out_rr_arbiter
module tb_lii_out_rr_arbiter;

    localparam int         N        = 4;
    localparam int         PW       = 32;
    localparam logic [7:0] SRC      = 8'h5A;
    localparam logic [7:0] DST_BASE = 8'hD0;

    typedef struct packed {
        logic [1:0]    sel;
        logic [PW-1:0] data;
        logic [7:0]    dst;
    } beat_t;

    logic            aclk;
    logic            arstn;
    logic [N*PW-1:0] s_tdata;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tready;
    logic [N*8-1:0]  s_dst;
    logic [PW-1:0]   m_tdata;
    logic            m_tvalid;
    logic            m_tready;
    logic [7:0]      m_src;
    logic [7:0]      m_dst;
    logic [1:0]      m_sel;

    int     n_cmp;
    int     n_err;
    int     seq     [N];
    int     exp_seq [N];
    logic [N-1:0] hs_latched;
    beat_t  exp_q[$];

    lii_out_rr_arbiter #(
        .N      (N),
        .PW     (PW),
        .SRC_ID (SRC),
        .BURST  (4)
    ) dut (
        .aclk     (aclk),
        .arstn    (arstn),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_dst    (s_dst),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_src    (m_src),
        .m_dst    (m_dst),
        .m_sel    (m_sel)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Scoreboard: every beat leaving the phy port must be the next expected one
    always @(negedge aclk) begin
        if (arstn && m_tvalid && m_tready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got sel=%0d data=%h dst=%h, required no beat", m_sel, m_tdata, m_dst);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                if (m_sel !== e.sel || m_tdata !== e.data || m_dst !== e.dst || m_src !== SRC) begin
                    n_err++;
                    $display("FAIL sb_beat: got sel=%0d data=%h dst=%h src=%h, required sel=%0d data=%h dst=%h src=%h",
                             m_sel, m_tdata, m_dst, m_src, e.sel, e.data, e.dst, SRC);
                end
            end
        end
    end

    task automatic drive_data();
        for (int i = 0; i < N; i++) begin
            s_tdata[i*PW +: PW] = {8'(i), 24'(seq[i])};
            s_dst[i*8 +: 8]     = DST_BASE + 8'(i);
        end
    endtask

    task automatic push_exp(input int sel);
        beat_t e;
        e.sel  = 2'(sel);
        e.data = {8'(sel), 24'(exp_seq[sel])};
        e.dst  = DST_BASE + 8'(sel);
        exp_seq[sel]++;
        exp_q.push_back(e);
    endtask

    task automatic at_neg();
        @(negedge aclk);
        hs_latched = s_tvalid & s_tready;
    endtask

    task automatic to_pos();
        @(posedge aclk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs_latched[i]) seq[i]++;
        end
        hs_latched = '0;
        drive_data();
    endtask

    task automatic do_reset();
        s_tvalid = '0;
        arstn    = 1'b0;
        hs_latched = '0;
        exp_q.delete();
        @(posedge aclk);
        #1;
        arstn = 1'b1;
        for (int i = 0; i < N; i++) exp_seq[i] = seq[i];
    endtask

    task automatic drain();
        for (int c = 0; c < 10 && (exp_q.size() != 0 || m_tvalid); c++) begin
            at_neg();
            to_pos();
        end
    endtask

    task automatic test_reset();
        arstn    = 1'b0;
        s_tvalid = '1;
        m_tready = 1'b1;
        to_pos();
        to_pos();
        at_neg();
        n_cmp++;
        if (m_tvalid !== 1'b0 || s_tready !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_idle: got m_tvalid=%b s_tready=%b, required 0 0000", m_tvalid, s_tready);
        end
        n_cmp++;
        if (m_src !== SRC || m_tdata !== '0 || m_dst !== 8'h00 || m_sel !== 2'd0) begin
            n_err++;
            $display("FAIL reset_regs: got src=%h data=%h dst=%h sel=%0d, required %h 0 00 0", m_src, m_tdata, m_dst, m_sel, SRC);
        end
        to_pos();
        arstn = 1'b1;
        at_neg();
        n_cmp++;
        if (s_tready !== 4'b0001 || m_tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_first_grant: got s_tready=%b m_tvalid=%b, required 0001 0", s_tready, m_tvalid);
        end
        push_exp(0);
        to_pos();
        s_tvalid = '0;
        at_neg();
        n_cmp++;
        if (m_tvalid !== 1'b1 || m_sel !== 2'd0) begin
            n_err++;
            $display("FAIL reset_first_beat: got m_tvalid=%b m_sel=%0d, required 1 0", m_tvalid, m_sel);
        end
        to_pos();
        at_neg();
        n_cmp++;
        if (m_tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_empty: got m_tvalid=%b, required 0", m_tvalid);
        end
        to_pos();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL reset_sb_left: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_fairness();
        do_reset();
        m_tready = 1'b1;
        s_tvalid = '1;
        for (int k = 0; k < 8; k++) push_exp(k % N);
        for (int k = 0; k < 8; k++) begin
            at_neg();
            n_cmp++;
            if (s_tready !== 4'(1 << (k % N)) || (k > 0 && m_tvalid !== 1'b1)) begin
                n_err++;
                $display("FAIL fair_grant%0d: got s_tready=%b m_tvalid=%b, required %b 1", k, s_tready, m_tvalid, 4'(1 << (k % N)));
            end
            to_pos();
        end
        s_tvalid = '0;
        drain();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL fair_sb_left: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        m_tready = 1'b1;
        s_tvalid = '1;
        push_exp(0);
        push_exp(1);
        at_neg();
        to_pos();
        at_neg();
        to_pos();
        m_tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            at_neg();
            n_cmp++;
            if (s_tready !== 4'b0000 || m_tvalid !== 1'b1 || m_sel !== 2'd1 ||
                m_dst !== DST_BASE + 8'd1 || m_tdata !== {8'd1, 24'(exp_seq[1] - 1)}) begin
                n_err++;
                $display("FAIL bp_hold%0d: got s_tready=%b m_tvalid=%b sel=%0d dst=%h data=%h, required 0000 1 1 %h %h",
                         k, s_tready, m_tvalid, m_sel, m_dst, m_tdata, DST_BASE + 8'd1, {8'd1, 24'(exp_seq[1] - 1)});
            end
            to_pos();
        end
        m_tready = 1'b1;
        push_exp(2);
        push_exp(3);
        at_neg();
        n_cmp++;
        if (s_tready !== 4'b0100) begin
            n_err++;
            $display("FAIL bp_resume: got s_tready=%b, required 0100", s_tready);
        end
        to_pos();
        at_neg();
        to_pos();
        s_tvalid = '0;
        drain();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL bp_sb_left: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_sparse();
        logic [N-1:0] want [3];
        want[0] = 4'b0001;
        want[1] = 4'b0100;
        want[2] = 4'b0001;
        do_reset();
        m_tready = 1'b1;
        s_tvalid = 4'b0100;
        push_exp(2);
        at_neg();
        to_pos();
        s_tvalid = 4'b0101;
        push_exp(0);
        push_exp(2);
        push_exp(0);
        for (int k = 0; k < 3; k++) begin
            at_neg();
            n_cmp++;
            if (s_tready !== want[k]) begin
                n_err++;
                $display("FAIL sparse_grant%0d: got s_tready=%b, required %b", k, s_tready, want[k]);
            end
            to_pos();
        end
        s_tvalid = '0;
        drain();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sparse_sb_left: got %0d pending, required 0", exp_q.size());
        end
    endtask

`ifdef LII_ARB_BURST_EN
    task automatic test_burst();
        do_reset();
        m_tready = 1'b1;
        s_tvalid = '1;
        for (int k = 0; k < 8; k++) push_exp(k / 4);
        for (int k = 0; k < 8; k++) begin
            at_neg();
            n_cmp++;
            if (s_tready !== 4'(1 << (k / 4))) begin
                n_err++;
                $display("FAIL burst_grant%0d: got s_tready=%b, required %b", k, s_tready, 4'(1 << (k / 4)));
            end
            to_pos();
        end
        s_tvalid = '0;
        drain();
        do_reset();
        s_tvalid = '1;
        push_exp(0);
        push_exp(0);
        for (int k = 0; k < 2; k++) begin
            at_neg();
            to_pos();
        end
        s_tvalid = 4'b1110;
        for (int k = 0; k < 4; k++) push_exp(1);
        push_exp(2);
        for (int k = 0; k < 5; k++) begin
            at_neg();
            n_cmp++;
            if (s_tready !== (k < 4 ? 4'b0010 : 4'b0100) || m_tvalid !== 1'b1) begin
                n_err++;
                $display("FAIL burst_drop%0d: got s_tready=%b m_tvalid=%b, required %b 1", k, s_tready, m_tvalid, (k < 4 ? 4'b0010 : 4'b0100));
            end
            to_pos();
        end
        s_tvalid = '0;
        drain();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL burst_sb_left: got %0d pending, required 0", exp_q.size());
        end
    endtask
`endif

    task automatic test_reset_mid();
        do_reset();
        m_tready = 1'b1;
        s_tvalid = 4'b0001;
        push_exp(0);
        push_exp(0);
        at_neg();
        to_pos();
        at_neg();
        to_pos();
        m_tready = 1'b0;
        s_tvalid = '1;
        at_neg();
        #2;
        arstn = 1'b0;
        hs_latched = '0;
        #1;
        n_cmp++;
        if (m_tvalid !== 1'b0 || m_tdata !== '0 || s_tready !== 4'b0000) begin
            n_err++;
            $display("FAIL mid_reset_async: got m_tvalid=%b data=%h s_tready=%b, required 0 0 0000", m_tvalid, m_tdata, s_tready);
        end
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_seq[i] = seq[i];
        to_pos();
        arstn = 1'b1;
        m_tready = 1'b1;
        at_neg();
        n_cmp++;
        if (s_tready !== 4'b0001 || m_tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_restart: got s_tready=%b m_tvalid=%b, required 0001 0", s_tready, m_tvalid);
        end
        push_exp(0);
        to_pos();
        s_tvalid = '0;
        drain();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL mid_sb_left: got %0d pending, required 0", exp_q.size());
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        arstn      = 1'b0;
        s_tvalid   = '0;
        m_tready   = 1'b0;
        hs_latched = '0;
        for (int i = 0; i < N; i++) begin
            seq[i]     = 16 * i + 1;
            exp_seq[i] = 16 * i + 1;
        end
        drive_data();
        test_reset();
`ifdef LII_ARB_BURST_EN
        test_burst();
`else
        test_fairness();
        test_backpressure();
        test_sparse();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
